bp_gshare_btb: RTL and testbench
================================

Name: bp_gshare_btb

Overview:
- Parametrised successor to the fetch-stage branch predictor: gshare direction predictor (2-bit counter PHT indexed by PC XOR speculative global history) plus a direct-mapped tagged BTB.
- Speculative global history (GHR) is kept internally. A history snapshot travels with each prediction and is returned at resolve time; this replaces the OBQ index.
- Sits between fetch (lookup) and execute (resolve/update); produces a registered next-PC one cycle after lookup.

Parameters:
- GH_BITS, 8, GHR width; PHT has 2^GH_BITS entries.
- BTB_ENTRIES, 32, BTB rows (power of 2, >=2).
- BTB_TAG_BITS, 10, tag width stored per BTB row.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  fetch-path enable; gates lookup and speculative GHR update only
- if_valid  in  1  valid branch at fetch
- if_pc  in  32  fetch PC
- ex_valid  in  1  resolved branch this cycle
- ex_pc  in  32  PC of resolved branch
- ex_taken  in  1  actual direction
- ex_target  in  32  calculated target PC
- ex_mispredict  in  1  direction or target was mispredicted (qualified by ex_valid)
- ex_ghr  in  GH_BITS  snapshot returned with the branch (its pred_ghr)
- pred_valid  out  1  prediction outputs valid
- pred_taken  out  1  predicted taken
- pred_pc  out  32  predicted next PC
- pred_ghr  out  GH_BITS  GHR value used for this lookup (pre-update)

Behaviour:
- Reset (async, active-high):
  - PHT entries = 2'b01 (weakly not-taken); all BTB valid bits = 0; GHR = 0.
  - pred_valid = 0, pred_taken = 0, pred_pc = 0, pred_ghr = 0.
  - Reset mid-operation discards all state, including in-flight predictions.
- Indexing:
  - pht_idx = pc[GH_BITS+1:2] ^ GHR (lookup) or ex_pc[GH_BITS+1:2] ^ ex_ghr (update).
  - btb_idx = pc[log2(BTB_ENTRIES)+1:2].
  - btb_tag = pc[BTB_TAG_BITS+log2(BTB_ENTRIES)+1 : log2(BTB_ENTRIES)+2].
  - BTB stores target[31:2]; the output target has [1:0] = 2'b00.
- Lookup (cycle N, enable & if_valid & !(ex_valid & ex_mispredict)):
  - dir = PHT[pht_idx][1]; hit = valid & tag match.
  - taken = dir & hit.
- Registered outputs at N+1:
  - pred_valid = 1, pred_taken = taken, pred_pc = taken ? BTB target : if_pc+4 (mod 2^32), pred_ghr = GHR at N.
  - GHR <= {GHR[GH_BITS-2:0], taken} at the same edge.
- Idle cycles:
  - When no lookup occurs (enable=0, if_valid=0, or squashed): pred_valid <= 0; other outputs hold; GHR holds unless recovering.
- Resolve (ex_valid, independent of enable):
  - PHT[update idx] saturating ±1 by ex_taken (11 stays at 11 on taken, 00 stays at 00 on not-taken).
  - If ex_taken: BTB[btb_idx(ex_pc)] <= {valid=1, tag(ex_pc), ex_target[31:2]}; this overwrites any alias.
  - Not-taken resolves do not modify the BTB.
- Mispredict recovery (ex_valid & ex_mispredict):
  - GHR <= {ex_ghr[GH_BITS-2:0], ex_taken}.
  - A fetch lookup in the same cycle is squashed: pred_valid <= 0, and no speculative GHR shift.
  - Recovery takes priority over speculative update.
- Simultaneous read/write of the same PHT or BTB entry: the lookup sees the old (pre-update) value; the write takes effect at the edge.
- Single-cycle throughput: one lookup and one resolve per cycle. No back-pressure.

Test Plan:
- Reset, then lookup if_pc=0x100 with GH_BITS=8 -> next cycle pred_valid=1, pred_taken=0, pred_pc=0x104, pred_ghr=0x00; GHR becomes 0x00.
- Resolve ex_pc=0x100, ex_ghr=0, ex_taken=1, ex_target=0x200, twice (counter 01->10->11); then lookup 0x100 with GHR=0 -> pred_taken=1, pred_pc=0x200, pred_ghr=0x00, GHR becomes 0x01.
- Saturation: three more taken resolves keep the counter at 11; one not-taken resolve (10) still predicts taken; a second not-taken (01) predicts not-taken, pred_pc=0x104.
- Mispredict recovery: after three taken lookups (GHR=0x07), assert ex_mispredict with ex_ghr=0x03, ex_taken=0 alongside if_valid -> pred_valid=0 next cycle, GHR=0x06.
- BTB alias: train taken ex_pc=0x100 -> 0x200; lookup 0x100+4*BTB_ENTRIES (=0x180, same index, different tag) with counter strong-taken -> pred_taken=0, pred_pc=0x184.
- Same-cycle hazard: resolve and lookup hit the same PHT entry at counter 01 with ex_taken=1 -> lookup predicts not-taken; the following lookup sees 10 and predicts taken if the BTB hits. Also check enable=0 with ex_valid=1 -> PHT/BTB update, pred_valid=0, GHR unchanged.

Source files
------------

// File: rtl/bp_gshare_btb.sv
// Fetch-stage branch predictor: gshare direction (2-bit PHT indexed by PC ^ GHR)
// plus a direct-mapped tagged BTB, with a registered next-PC one cycle after lookup.
module bp_gshare_btb #(
    parameter int unsigned GH_BITS      = 8,
    parameter int unsigned BTB_ENTRIES  = 32,
    parameter int unsigned BTB_TAG_BITS = 10
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               if_valid_i,
    input  logic [31:0]        if_pc_i,
    input  logic               ex_valid_i,
    input  logic [31:0]        ex_pc_i,
    input  logic               ex_taken_i,
    input  logic [31:0]        ex_target_i,
    input  logic               ex_mispredict_i,
    input  logic [GH_BITS-1:0] ex_ghr_i,
    output logic               pred_valid_o,
    output logic               pred_taken_o,
    output logic [31:0]        pred_pc_o,
    output logic [GH_BITS-1:0] pred_ghr_o
);

    localparam int unsigned IDX_W  = $clog2(BTB_ENTRIES);
    localparam int unsigned PHT_N  = 1 << GH_BITS;
    localparam int unsigned TAG_LO = IDX_W + 2;
    localparam int unsigned TAG_HI = BTB_TAG_BITS + IDX_W + 1;

    logic [PHT_N-1:0][1:0]     pht_q;
    logic [BTB_ENTRIES-1:0]    btb_vld_q;
    logic [BTB_TAG_BITS-1:0]   btb_tag_q [BTB_ENTRIES];
    logic [29:0]               btb_tgt_q [BTB_ENTRIES];

    logic [GH_BITS-1:0]        ghr_q, ghr_d;
    logic                      pred_valid_q, pred_valid_d;
    logic                      pred_taken_q, pred_taken_d;
    logic [31:0]               pred_pc_q, pred_pc_d;
    logic [GH_BITS-1:0]        pred_ghr_q, pred_ghr_d;

    logic [GH_BITS-1:0]        lk_pht_idx, up_pht_idx;
    logic [IDX_W-1:0]          lk_btb_idx, up_btb_idx;
    logic [BTB_TAG_BITS-1:0]   lk_tag, up_tag;
    logic                      lk_hit, lk_taken, lookup, recover;
    logic [1:0]                up_ctr, up_ctr_d;
    logic                      unused_ok;

    assign unused_ok = ^{ex_pc_i, ex_target_i[1:0]};

    // Lookup path reads array state before this edge's resolve write lands.
    assign lk_pht_idx = if_pc_i[GH_BITS+1:2] ^ ghr_q;
    assign lk_btb_idx = if_pc_i[IDX_W+1:2];
    assign lk_tag     = if_pc_i[TAG_HI:TAG_LO];
    assign lk_hit     = btb_vld_q[lk_btb_idx] && (btb_tag_q[lk_btb_idx] == lk_tag);
    assign lk_taken   = pht_q[lk_pht_idx][1] & lk_hit;

    assign recover    = ex_valid_i & ex_mispredict_i;
    assign lookup     = enable_i & if_valid_i & ~recover;

    assign up_pht_idx = ex_pc_i[GH_BITS+1:2] ^ ex_ghr_i;
    assign up_btb_idx = ex_pc_i[IDX_W+1:2];
    assign up_tag     = ex_pc_i[TAG_HI:TAG_LO];
    assign up_ctr     = pht_q[up_pht_idx];

    always_comb begin
        up_ctr_d = up_ctr;
        if (ex_taken_i) begin
            if (up_ctr != 2'b11) up_ctr_d = up_ctr + 2'd1;
        end else begin
            if (up_ctr != 2'b00) up_ctr_d = up_ctr - 2'd1;
        end
    end

    always_comb begin
        ghr_d        = ghr_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_pc_d    = pred_pc_q;
        pred_ghr_d   = pred_ghr_q;
        if (recover) begin
            ghr_d = {ex_ghr_i[GH_BITS-2:0], ex_taken_i};
        end else if (lookup) begin
            ghr_d        = {ghr_q[GH_BITS-2:0], lk_taken};
            pred_valid_d = 1'b1;
            pred_taken_d = lk_taken;
            pred_pc_d    = lk_taken ? {btb_tgt_q[lk_btb_idx], 2'b00} : (if_pc_i + 32'd4);
            pred_ghr_d   = ghr_q;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_pc_q    <= '0;
            pred_ghr_q   <= '0;
        end else begin
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_pc_q    <= pred_pc_d;
            pred_ghr_q   <= pred_ghr_d;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pht_q     <= {PHT_N{2'b01}};
            btb_vld_q <= '0;
        end else if (ex_valid_i) begin
            pht_q[up_pht_idx] <= up_ctr_d;
            if (ex_taken_i) btb_vld_q[up_btb_idx] <= 1'b1;
        end
    end

    // Tag/target storage needs no reset: the valid bits gate every hit.
    always_ff @(posedge clock_i) begin
        if (ex_valid_i && ex_taken_i) begin
            btb_tag_q[up_btb_idx] <= up_tag;
            btb_tgt_q[up_btb_idx] <= ex_target_i[31:2];
        end
    end

    assign pred_valid_o = pred_valid_q;
    assign pred_taken_o = pred_taken_q;
    assign pred_pc_o    = pred_pc_q;
    assign pred_ghr_o   = pred_ghr_q;

endmodule

// File: tb/tb_bp_gshare_btb.sv
// Table-driven bench for bp_gshare_btb: each row is one cycle of stimulus plus the
// registered outputs expected after that edge, queued and compared one cycle later.
module tb_bp_gshare_btb;

    typedef struct {
        logic        en;
        logic        ifv;
        logic [31:0] ifpc;
        logic        exv;
        logic [31:0] expc;
        logic        ext;
        logic [31:0] extgt;
        logic        exm;
        logic [7:0]  exghr;
        logic        ev;
        logic        et;
        logic [31:0] epc;
        logic [7:0]  eghr;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_mispredict = 1'b0;
    logic [7:0]  ex_ghr = '0;
    logic        pred_valid;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic [7:0]  pred_ghr;

    int unsigned total = 0;
    int unsigned bad = 0;

    vec_t sb[$];
    vec_t main_tbl[$];
    vec_t post_tbl[$];

    bp_gshare_btb #(
        .GH_BITS(8),
        .BTB_ENTRIES(32),
        .BTB_TAG_BITS(10)
    ) dut (
        .clock_i(clock),
        .reset_i(reset),
        .enable_i(enable),
        .if_valid_i(if_valid),
        .if_pc_i(if_pc),
        .ex_valid_i(ex_valid),
        .ex_pc_i(ex_pc),
        .ex_taken_i(ex_taken),
        .ex_target_i(ex_target),
        .ex_mispredict_i(ex_mispredict),
        .ex_ghr_i(ex_ghr),
        .pred_valid_o(pred_valid),
        .pred_taken_o(pred_taken),
        .pred_pc_o(pred_pc),
        .pred_ghr_o(pred_ghr)
    );

    always #5 clock = ~clock;

    function automatic vec_t v(input logic en, input logic ifv, input logic [31:0] ifpc,
                               input logic exv, input logic [31:0] expc, input logic ext,
                               input logic [31:0] extgt, input logic exm, input logic [7:0] exghr,
                               input logic ev, input logic et, input logic [31:0] epc,
                               input logic [7:0] eghr);
        vec_t r;
        r.en = en; r.ifv = ifv; r.ifpc = ifpc;
        r.exv = exv; r.expc = expc; r.ext = ext; r.extgt = extgt; r.exm = exm; r.exghr = exghr;
        r.ev = ev; r.et = et; r.epc = epc; r.eghr = eghr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, {31'd0, pred_valid}, 32'd0);
        chk({tag, ".taken"}, {31'd0, pred_taken}, 32'd0);
        chk({tag, ".pc"},    pred_pc, 32'd0);
        chk({tag, ".ghr"},   {24'd0, pred_ghr}, 32'd0);
    endtask

    task automatic drive_idle();
        enable = 1'b1; if_valid = 1'b0; if_pc = '0;
        ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
        ex_mispredict = 1'b0; ex_ghr = '0;
    endtask

    task automatic run_vec(input vec_t r, input string tag);
        vec_t e;
        enable = r.en; if_valid = r.ifv; if_pc = r.ifpc;
        ex_valid = r.exv; ex_pc = r.expc; ex_taken = r.ext; ex_target = r.extgt;
        ex_mispredict = r.exm; ex_ghr = r.exghr;
        sb.push_back(r);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk({tag, ".valid"}, {31'd0, pred_valid}, {31'd0, e.ev});
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, e.et});
        chk({tag, ".pc"},    pred_pc, e.epc);
        chk({tag, ".ghr"},   {24'd0, pred_ghr}, {24'd0, e.eghr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // en ifv ifpc | exv expc ext extgt exm exghr | ev et epc eghr
        main_tbl.push_back(v(1,1,32'h100, 0,0,0,0,0,0,            1,0,32'h104,8'h00));
        main_tbl.push_back(v(1,0,0, 1,32'h100,1,32'h200,0,8'h00,  0,0,32'h104,8'h00));
        main_tbl.push_back(v(1,0,0, 1,32'h100,1,32'h200,0,8'h00,  0,0,32'h104,8'h00));
        main_tbl.push_back(v(1,1,32'h100, 0,0,0,0,0,0,            1,1,32'h200,8'h00));
        for (int i = 0; i < 3; i++)
            main_tbl.push_back(v(1,0,0, 1,32'h100,1,32'h200,0,8'h00, 0,1,32'h200,8'h00));
        main_tbl.push_back(v(1,0,0, 1,32'h100,0,0,0,8'h00,        0,1,32'h200,8'h00));
        main_tbl.push_back(v(1,0,0, 1,32'h1000,0,0,1,8'h00,       0,1,32'h200,8'h00));
        main_tbl.push_back(v(1,1,32'h100, 0,0,0,0,0,0,            1,1,32'h200,8'h00));
        main_tbl.push_back(v(1,0,0, 1,32'h100,0,0,0,8'h00,        0,1,32'h200,8'h00));
        main_tbl.push_back(v(1,0,0, 1,32'h1000,0,0,1,8'h00,       0,1,32'h200,8'h00));
        main_tbl.push_back(v(1,1,32'h100, 0,0,0,0,0,0,            1,0,32'h104,8'h00));
        for (int i = 0; i < 2; i++) main_tbl.push_back(v(1,0,0, 1,32'h100,1,32'h200,0,8'h00, 0,0,32'h104,8'h00));
        for (int i = 0; i < 2; i++) main_tbl.push_back(v(1,0,0, 1,32'h100,1,32'h200,0,8'h01, 0,0,32'h104,8'h00));
        for (int i = 0; i < 2; i++) main_tbl.push_back(v(1,0,0, 1,32'h100,1,32'h200,0,8'h03, 0,0,32'h104,8'h00));
        main_tbl.push_back(v(1,1,32'h100, 0,0,0,0,0,0,            1,1,32'h200,8'h00));
        main_tbl.push_back(v(1,1,32'h100, 0,0,0,0,0,0,            1,1,32'h200,8'h01));
        main_tbl.push_back(v(1,1,32'h100, 0,0,0,0,0,0,            1,1,32'h200,8'h03));
        main_tbl.push_back(v(1,1,32'h100, 1,32'h100,0,0,1,8'h03,  0,1,32'h200,8'h03));
        main_tbl.push_back(v(1,1,32'h100, 0,0,0,0,0,0,            1,0,32'h104,8'h06));
        for (int i = 0; i < 2; i++) main_tbl.push_back(v(1,0,0, 1,32'h180,1,32'h300,0,8'h0C, 0,0,32'h104,8'h06));
        main_tbl.push_back(v(1,0,0, 1,32'h100,1,32'h200,0,8'h00,  0,0,32'h104,8'h06));
        main_tbl.push_back(v(1,1,32'h180, 0,0,0,0,0,0,            1,0,32'h184,8'h0C));
        main_tbl.push_back(v(1,1,32'h100, 1,32'h100,1,32'h200,0,8'h18, 1,0,32'h104,8'h18));
        main_tbl.push_back(v(1,0,0, 1,32'h1000,0,0,1,8'h0C,       0,0,32'h104,8'h18));
        main_tbl.push_back(v(1,1,32'h100, 0,0,0,0,0,0,            1,1,32'h200,8'h18));
        main_tbl.push_back(v(0,1,32'h180, 1,32'h180,1,32'h300,0,8'h31, 0,1,32'h200,8'h18));
        main_tbl.push_back(v(1,1,32'h180, 0,0,0,0,0,0,            1,1,32'h300,8'h31));
        main_tbl.push_back(v(1,1,32'hFFFFFFFC, 0,0,0,0,0,0,       1,0,32'h0,8'h63));
        main_tbl.push_back(v(1,1,32'h100, 0,0,0,0,0,0,            1,0,32'h104,8'hC6));

        // after a mid-run reset: PHT, BTB valid bits and GHR must all be back to defaults
        for (int i = 0; i < 2; i++) post_tbl.push_back(v(1,0,0, 1,32'h104,1,32'h400,0,8'h01, 0,0,32'h0,8'h00));
        post_tbl.push_back(v(1,1,32'h104, 0,0,0,0,0,0,            1,0,32'h108,8'h00));
        post_tbl.push_back(v(1,1,32'h100, 0,0,0,0,0,0,            1,0,32'h104,8'h00));
        for (int i = 0; i < 2; i++) post_tbl.push_back(v(1,0,0, 1,32'h104,1,32'h400,0,8'h00, 0,0,32'h104,8'h00));
        post_tbl.push_back(v(1,1,32'h104, 0,0,0,0,0,0,            1,1,32'h400,8'h00));

        drive_idle();
        repeat (2) @(posedge clock);
        #1;
        chk_zero("reset_hold");
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_zero("post_reset_idle");

        for (int i = 0; i < main_tbl.size(); i++)
            run_vec(main_tbl[i], $sformatf("main[%0d]", i));

        drive_idle();
        #3;
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        @(posedge clock);
        #1;
        chk_zero("reset_edge");
        reset = 1'b0;

        for (int i = 0; i < post_tbl.size(); i++)
            run_vec(post_tbl[i], $sformatf("post[%0d]", i));

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
